// File: rtl/ped_signal_ctrl.sv
// Pedestrian crosswalk controller: two independent channels (NS, EW) that grant WALK and a
// flashing clearance countdown at the onset of the parallel vehicle GREEN.
module ped_signal_ctrl #(
    parameter int unsigned WALK_TIME  = 15,
    parameter int unsigned CLEAR_TIME = 10,
    parameter int unsigned CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [1:0]       ns_light,
    input  logic [1:0]       ew_light,
    input  logic             ns_btn,
    input  logic             ew_btn,
    output logic             ns_walk,
    output logic             ns_dont_walk,
    output logic             ns_flash,
    output logic [CNT_W-1:0] ns_countdown,
    output logic             ns_req,
    output logic             ew_walk,
    output logic             ew_dont_walk,
    output logic             ew_flash,
    output logic [CNT_W-1:0] ew_countdown,
    output logic             ew_req,
    output logic             abort
);

    localparam logic [1:0]       LightGreen = 2'd0;
    localparam logic [1:0]       LightRed   = 2'd2;
    localparam logic [CNT_W-1:0] WalkLast   = CNT_W'(WALK_TIME - 1);
    localparam logic [CNT_W-1:0] ClearInit  = CNT_W'(CLEAR_TIME);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWalk  = 2'd1,
        StClear = 2'd2
    } state_e;

    // Channel 0 is NS, channel 1 is EW.
    logic [1:0]       light_v     [2];
    logic [1:0]       btn_v;
    logic [1:0]       walk_v;
    logic [1:0]       dont_walk_v;
    logic [1:0]       flash_v;
    logic [1:0]       req_v;
    logic [1:0]       abort_v;
    logic [CNT_W-1:0] countdown_v [2];
    logic             abort_q;

    assign light_v[0] = ns_light;
    assign light_v[1] = ew_light;
    assign btn_v      = {ew_btn, ns_btn};

    for (genvar c = 0; c < 2; c++) begin : g_chan
        state_e           state_q, state_d;
        logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
        logic [CNT_W-1:0] countdown_q, countdown_d;
        logic             flash_q, flash_d;
        logic             req_q, req_d;
        logic [2:0]       sync_q;
        logic [1:0]       prev_light_q;
        logic             is_green, green_start, btn_edge, abort_c;
        logic             walk_c, dont_walk_c;

        assign is_green    = (light_v[c] == LightGreen);
        assign green_start = is_green && (prev_light_q != LightGreen);
        // sync_q[1:0] is the synchroniser, sync_q[2] the delayed copy for edge detection.
        assign btn_edge    = sync_q[1] & ~sync_q[2];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q      <= StIdle;
                tick_cnt_q   <= '0;
                countdown_q  <= '0;
                flash_q      <= 1'b0;
                req_q        <= 1'b0;
                sync_q       <= '0;
                prev_light_q <= LightRed;
            end else begin
                state_q      <= state_d;
                tick_cnt_q   <= tick_cnt_d;
                countdown_q  <= countdown_d;
                flash_q      <= flash_d;
                req_q        <= req_d;
                sync_q       <= {sync_q[1:0], btn_v[c]};
                prev_light_q <= light_v[c];
            end
        end

        always_comb begin
            state_d     = state_q;
            tick_cnt_d  = tick_cnt_q;
            countdown_d = countdown_q;
            flash_d     = flash_q;
            req_d       = req_q;
            abort_c     = 1'b0;
            case (state_q)
                StIdle: begin
                    if ((req_q || btn_edge) && green_start) begin
                        state_d    = StWalk;
                        tick_cnt_d = '0;
                        req_d      = 1'b0;
                    end else if (btn_edge) begin
                        req_d = 1'b1;
                    end
                end
                StWalk: begin
                    if (!is_green) begin
                        state_d = StIdle;
                        abort_c = 1'b1;
                    end else if (tick) begin
                        if (tick_cnt_q == WalkLast) begin
                            state_d     = StClear;
                            countdown_d = ClearInit;
                            flash_d     = 1'b1;
                        end else begin
                            tick_cnt_d = tick_cnt_q + CntOne;
                        end
                    end
                end
                StClear: begin
                    if (btn_edge) req_d = 1'b1;
                    if (!is_green) begin
                        state_d     = StIdle;
                        abort_c     = 1'b1;
                        countdown_d = '0;
                        flash_d     = 1'b0;
                    end else if (tick) begin
                        if (countdown_q == CntOne) begin
                            state_d     = StIdle;
                            countdown_d = '0;
                            flash_d     = 1'b0;
                        end else begin
                            countdown_d = countdown_q - CntOne;
                            flash_d     = ~flash_q;
                        end
                    end
                end
                default: begin
                    state_d     = StIdle;
                    tick_cnt_d  = '0;
                    countdown_d = '0;
                    flash_d     = 1'b0;
                end
            endcase
        end

        always_comb begin
            walk_c      = 1'b0;
            dont_walk_c = 1'b1;
            case (state_q)
                StWalk: begin
                    walk_c      = 1'b1;
                    dont_walk_c = 1'b0;
                end
                StClear: dont_walk_c = flash_q;
                default: dont_walk_c = 1'b1;
            endcase
        end

        assign walk_v[c]      = walk_c;
        assign dont_walk_v[c] = dont_walk_c;
        assign flash_v[c]     = flash_q;
        assign req_v[c]       = req_q;
        assign abort_v[c]     = abort_c;
        assign countdown_v[c] = countdown_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) abort_q <= 1'b0;
        else        abort_q <= |abort_v;
    end

    assign ns_walk      = walk_v[0];
    assign ns_dont_walk = dont_walk_v[0];
    assign ns_flash     = flash_v[0];
    assign ns_countdown = countdown_v[0];
    assign ns_req       = req_v[0];
    assign ew_walk      = walk_v[1];
    assign ew_dont_walk = dont_walk_v[1];
    assign ew_flash     = flash_v[1];
    assign ew_countdown = countdown_v[1];
    assign ew_req       = req_v[1];
    assign abort        = abort_q;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed bench for ped_signal_ctrl; expected values are hand-derived from the cycle timing.
module tb_ped_signal_ctrl;

    localparam logic [1:0] Green  = 2'd0;
    localparam logic [1:0] Yellow = 2'd1;
    localparam logic [1:0] Red    = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] ns_light = Red;
    logic [1:0] ew_light = Red;
    logic       ns_btn = 1'b0;
    logic       ew_btn = 1'b0;
    logic       ns_walk, ns_dont_walk, ns_flash, ns_req;
    logic       ew_walk, ew_dont_walk, ew_flash, ew_req;
    logic [5:0] ns_countdown, ew_countdown;
    logic       abort;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ped_signal_ctrl #(
        .WALK_TIME (15),
        .CLEAR_TIME(10),
        .CNT_W     (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .ns_light    (ns_light),
        .ew_light    (ew_light),
        .ns_btn      (ns_btn),
        .ew_btn      (ew_btn),
        .ns_walk     (ns_walk),
        .ns_dont_walk(ns_dont_walk),
        .ns_flash    (ns_flash),
        .ns_countdown(ns_countdown),
        .ns_req      (ns_req),
        .ew_walk     (ew_walk),
        .ew_dont_walk(ew_dont_walk),
        .ew_flash    (ew_flash),
        .ew_countdown(ew_countdown),
        .ew_req      (ew_req),
        .abort       (abort)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_ticks(input int n);
        tick = 1'b1;
        step(n);
        tick = 1'b0;
    endtask

    task automatic check_idle_ns(input string tag);
        check({tag, "_ns_walk"}, ns_walk, 0);
        check({tag, "_ns_dw"}, ns_dont_walk, 1);
        check({tag, "_ns_cd"}, ns_countdown, 0);
        check({tag, "_ns_flash"}, ns_flash, 0);
    endtask

    initial begin
        // 1. Reset
        #2 rst_n = 1'b0;
        step(2);
        check_idle_ns("rst");
        check("rst_ns_req", ns_req, 0);
        check("rst_ew_walk", ew_walk, 0);
        check("rst_ew_dw", ew_dont_walk, 1);
        check("rst_ew_cd", ew_countdown, 0);
        check("rst_ew_req", ew_req, 0);
        check("rst_abort", abort, 0);
        rst_n = 1'b1;
        step(200);
        check_idle_ns("quiet");
        check("quiet_ew_dw", ew_dont_walk, 1);
        check("quiet_req", {ns_req, ew_req}, 0);

        // 2. Full NS service: request lands on the 3rd edge
        ns_btn = 1'b1;
        step(2);
        check("req_edge2", ns_req, 0);
        step(1);
        check("req_edge3", ns_req, 1);
        ns_btn   = 1'b0;
        ns_light = Green;
        step(1);
        check("walk_on", ns_walk, 1);
        check("walk_dw", ns_dont_walk, 0);
        check("walk_req_clr", ns_req, 0);
        do_ticks(14);
        check("walk_t14", ns_walk, 1);
        check("walk_t14_cd", ns_countdown, 0);
        do_ticks(1);
        check("clr_walk", ns_walk, 0);
        check("clr_cd0", ns_countdown, 10);
        check("clr_flash0", ns_flash, 1);
        check("clr_dw0", ns_dont_walk, 1);
        for (int i = 1; i < 10; i++) begin
            do_ticks(1);
            check("clr_cd", ns_countdown, 10 - i);
            check("clr_flash", ns_flash, (i % 2 == 0) ? 1 : 0);
            check("clr_dw", ns_dont_walk, (i % 2 == 0) ? 1 : 0);
        end
        do_ticks(1);
        check_idle_ns("clr_done");
        check("clr_done_abort", abort, 0);
        ns_light = Red;
        step(2);

        // 3. EW request mid-green waits for the next onset
        ew_light = Green;
        step(2);
        ew_btn = 1'b1;
        step(3);
        ew_btn = 1'b0;
        check("midg_req", ew_req, 1);
        step(5);
        check("midg_nowalk", ew_walk, 0);
        ew_light = Yellow;
        step(2);
        ew_light = Red;
        step(2);
        ew_light = Green;
        step(1);
        check("onset_walk", ew_walk, 1);
        check("onset_req", ew_req, 0);
        ew_light = Red;
        step(1);
        check("ew_abort", abort, 1);
        check("ew_abort_walk", ew_walk, 0);
        step(1);
        check("ew_abort_pulse", abort, 0);

        // 4. Abort in WALK, then abort in CLEAR with coincident tick
        ns_btn = 1'b1;
        step(3);
        ns_btn   = 1'b0;
        ns_light = Green;
        step(1);
        check("ab_walk", ns_walk, 1);
        do_ticks(7);
        ns_light = Yellow;
        step(1);
        check("ab_w_walk", ns_walk, 0);
        check("ab_w_dw", ns_dont_walk, 1);
        check("ab_w_abort", abort, 1);
        step(1);
        check("ab_w_pulse", abort, 0);
        ns_light = Red;
        ns_btn   = 1'b1;
        step(3);
        ns_btn   = 1'b0;
        ns_light = Green;
        step(1);
        do_ticks(15);
        do_ticks(6);
        check("ab_c_cd4", ns_countdown, 4);
        ns_light = Yellow;
        tick     = 1'b1;
        step(1);
        tick = 1'b0;
        check("ab_c_cd", ns_countdown, 0);
        check("ab_c_flash", ns_flash, 0);
        check("ab_c_dw", ns_dont_walk, 1);
        check("ab_c_abort", abort, 1);
        ns_light = Red;
        step(2);

        // 5. Simultaneous buttons, each served in its own green; held button = one request
        ns_btn = 1'b1;
        ew_btn = 1'b1;
        step(3);
        ns_btn = 1'b0;
        ew_btn = 1'b0;
        check("both_req", {ns_req, ew_req}, 2'b11);
        ns_light = Green;
        step(1);
        check("both_ns_walk", ns_walk, 1);
        check("both_ew_wait", {ew_walk, ew_req}, 2'b01);
        do_ticks(25);
        check_idle_ns("both_ns_done");
        ns_light = Red;
        ew_light = Green;
        step(1);
        check("both_ew_walk", {ew_walk, ns_walk}, 2'b10);
        check("both_ew_req", ew_req, 0);
        ew_light = Red;
        step(2);
        ns_btn = 1'b1;
        step(100);
        check("held_req", ns_req, 1);
        ns_light = Green;
        step(1);
        check("held_walk", ns_walk, 1);
        ns_light = Red;
        step(2);
        ns_light = Green;
        step(2);
        check("held_once", ns_walk, 0);
        check("held_once_req", ns_req, 0);
        ns_btn   = 1'b0;
        ns_light = Red;
        step(2);

        // 6. Async reset mid-CLEAR with a pending request
        ns_btn = 1'b1;
        step(3);
        ns_btn   = 1'b0;
        ns_light = Green;
        step(1);
        do_ticks(15);
        ns_btn = 1'b1;
        do_ticks(3);
        ns_btn = 1'b0;
        do_ticks(1);
        check("pre_rst_cd", ns_countdown, 6);
        check("pre_rst_req", ns_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_ns("async_rst");
        check("async_rst_req", ns_req, 0);
        step(1);
        rst_n = 1'b1;
        step(2);
        check("post_rst_nowalk", ns_walk, 0);
        ns_light = Red;
        step(2);
        ns_light = Green;
        step(2);
        check("lost_req_nowalk", ns_walk, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
